sig_dump: RTL and testbench



---
 rtl/sig_dump_pkg.sv | 25 ++
 rtl/sig_dump_if.sv | 24 ++
 rtl/sig_stream_reg.sv | 32 +++
 rtl/sig_dump.sv | 180 ++++++++++++++++++
 tb/tb_sig_dump.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sig_dump_pkg.sv
// Shared types and defaults for the post-test signature extractor.
// The CSUM state exists only when SIG_DUMP_CHECKSUM_EN is defined.
package sig_dump_pkg;

    localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;
    localparam logic [31:0] SIG_BASE_DEF    = 32'h0000_2000;
    localparam int          TRIG_BIT        = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD,
        ST_CAP,
        ST_SEND,
`ifdef SIG_DUMP_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE
    } sig_state_e;

    function automatic logic [31:0] sig_word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/sig_dump_if.sv
// Snooped write bus, data-memory read port and output stream of sig_dump.
// master = extractor side, slave = memory/stream-sink side.
interface sig_dump_if;
    logic        dmem_we;
    logic [31:0] dmem_waddr;
    logic [31:0] dmem_wdata;
    logic        mem_re;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;

    modport master (
        input  dmem_we, dmem_waddr, dmem_wdata, mem_rdata, out_ready,
        output mem_re, mem_raddr, out_valid, out_data, out_last
    );

    modport slave (
        output dmem_we, dmem_waddr, dmem_wdata, mem_rdata, out_ready,
        input  mem_re, mem_raddr, out_valid, out_data, out_last
    );
endinterface

// File: rtl/sig_stream_reg.sv
// Valid/ready output holding register: a load presents a new word, which is
// held stable until accepted. A load in the accept cycle chains the next word.
module sig_stream_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end

endmodule

// File: rtl/sig_dump.sv
// Signature extractor: waits for a tohost write, halts the core and streams
// header + SIG_WORDS memory words. Optional checksum word: SIG_DUMP_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | snooping for a tohost write with bit0 set
// HDR     | header word (tohost value) presented on the stream
// RD      | read strobe for signature word cnt
// CAP     | read data captured into the stream register
// SEND    | signature word presented on the stream
// CSUM    | checksum word presented (checksum build only)
// DONE    | stream complete, held until reset
module sig_dump
    import sig_dump_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEF,
    parameter logic [31:0] SIG_BASE    = SIG_BASE_DEF,
    parameter int unsigned SIG_WORDS   = 16
) (
    input  logic       clk,
    input  logic       rst,
    sig_dump_if.master bus,
    output logic       cpu_halt,
    output logic       done,
    output logic       pass
);

    localparam int unsigned CNT_W = (SIG_WORDS < 1) ? 1 : $clog2(SIG_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = (SIG_WORDS == 0) ? '0 : CNT_W'(SIG_WORDS - 1);
`ifdef SIG_DUMP_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    localparam bit HDR_LAST = (SIG_WORDS == 0) && !CSUM_EN;

    if (SIG_BASE[1:0] != 2'b00) begin : g_bad_align
        $error("sig_dump: SIG_BASE must be word aligned");
    end
    if ((64'(SIG_BASE) + 64'(SIG_WORDS) * 64'd4) > 64'h1_0000_0000) begin : g_bad_window
        $error("sig_dump: signature window exceeds the 32-bit address space");
    end
    if (SIG_WORDS > 1024) begin : g_bad_words
        $error("sig_dump: SIG_WORDS out of range 0..1024");
    end

    sig_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      tohost_q;
    logic             armed;
    logic             hs;
    logic             ld;
    logic [31:0]      ld_data;
    logic             ld_last;
    logic             tohost_ld;
    logic             cnt_inc;
    logic             finish;
`ifdef SIG_DUMP_CHECKSUM_EN
    logic [31:0]      csum_q;
`endif

    assign hs       = bus.out_valid && bus.out_ready;
    assign cpu_halt = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign pass     = (tohost_q == 32'h1);

    // armed blocks a trigger landing in the first clock after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            tohost_q <= '0;
            armed    <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (tohost_ld) begin
                tohost_q <= bus.dmem_wdata;
                cnt      <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef SIG_DUMP_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else if (tohost_ld) begin
            csum_q <= bus.dmem_wdata;
        end else if (state == ST_CAP) begin
            csum_q <= csum_q + bus.mem_rdata;
        end
    end
`endif

    always_comb begin
        state_nxt     = state;
        ld            = 1'b0;
        ld_data       = '0;
        ld_last       = 1'b0;
        tohost_ld     = 1'b0;
        cnt_inc       = 1'b0;
        finish        = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_raddr = '0;
        unique case (state)
            ST_IDLE: begin
                if (armed && bus.dmem_we && (bus.dmem_waddr == TOHOST_ADDR) &&
                    bus.dmem_wdata[TRIG_BIT]) begin
                    tohost_ld = 1'b1;
                    ld        = 1'b1;
                    ld_data   = bus.dmem_wdata;
                    ld_last   = HDR_LAST;
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (hs) begin
                    if (SIG_WORDS == 0) finish = 1'b1;
                    else                state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                bus.mem_re    = 1'b1;
                bus.mem_raddr = sig_word_addr(SIG_BASE, 32'(cnt));
                state_nxt     = ST_CAP;
            end
            ST_CAP: begin
                ld        = 1'b1;
                ld_data   = bus.mem_rdata;
                ld_last   = !CSUM_EN && (cnt == LAST_IDX);
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (hs) begin
                    cnt_inc = 1'b1;
                    if (cnt == LAST_IDX) finish = 1'b1;
                    else                 state_nxt = ST_RD;
                end
            end
`ifdef SIG_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (hs) state_nxt = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // the checksum word is loaded in the same cycle the final word is taken
        if (finish) begin
`ifdef SIG_DUMP_CHECKSUM_EN
            ld        = 1'b1;
            ld_data   = csum_q;
            ld_last   = 1'b1;
            state_nxt = ST_CSUM;
`else
            state_nxt = ST_DONE;
`endif
        end
    end

    sig_stream_reg #(.W(32)) u_stream (
        .clk       (clk),
        .rst       (rst),
        .load      (ld),
        .load_data (ld_data),
        .load_last (ld_last),
        .ready     (bus.out_ready),
        .valid     (bus.out_valid),
        .data      (bus.out_data),
        .last      (bus.out_last)
    );

endmodule

// File: tb/tb_sig_dump.sv
// Randomized self-checking bench for sig_dump: a 4-word instance with a memory
// model and stream monitor, plus a 0-word instance sharing the snoop bus.
module tb_sig_dump;

    localparam int unsigned NW     = 4;
    localparam logic [31:0] TOHOST = 32'h0000_1000;
    localparam logic [31:0] BASE   = 32'h0000_2000;
`ifdef SIG_DUMP_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sig_dump_if bus_a ();
    sig_dump_if bus_z ();
    logic halt_a, done_a, pass_a;
    logic halt_z, done_z, pass_z;

    sig_dump #(.TOHOST_ADDR(TOHOST), .SIG_BASE(BASE), .SIG_WORDS(NW)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.master),
        .cpu_halt(halt_a), .done(done_a), .pass(pass_a)
    );

    sig_dump #(.TOHOST_ADDR(TOHOST), .SIG_BASE(BASE), .SIG_WORDS(0)) dut_z (
        .clk(clk), .rst(rst), .bus(bus_z.master),
        .cpu_halt(halt_z), .done(done_z), .pass(pass_z)
    );

    assign bus_z.dmem_we    = bus_a.dmem_we;
    assign bus_z.dmem_waddr = bus_a.dmem_waddr;
    assign bus_z.dmem_wdata = bus_a.dmem_wdata;
    assign bus_z.mem_rdata  = 32'h0;
    assign bus_z.out_ready  = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // data memory: read data appears one cycle after the strobe, garbage otherwise
    logic [31:0] mem_a [NW];

    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        logic [31:0] off;
        int idx;
        off = a - BASE;
        if (a[1:0] != 2'b00 || off >= NW * 4) return 32'hBAD0_0000 ^ a;
        idx = int'(off >> 2);
        return mem_a[idx];
    endfunction

    always @(posedge clk) begin
        if (bus_a.mem_re) bus_a.mem_rdata <= mem_lookup(bus_a.mem_raddr);
        else              bus_a.mem_rdata <= 32'hDEAD_BEEF;
    end

    logic [31:0] got_q [$];
    bit          got_last [$];
    int          hs_cyc [$];
    logic [31:0] z_q [$];
    bit          z_last [$];
    bit          stall_pend = 1'b0;
    logic [31:0] stall_data;
    logic        stall_last;

    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_valid", 32'(bus_a.out_valid), 32'd1);
                check("stall_data", bus_a.out_data, stall_data);
                check("stall_last", 32'(bus_a.out_last), 32'(stall_last));
            end
            stall_pend = bus_a.out_valid && !bus_a.out_ready;
            stall_data = bus_a.out_data;
            stall_last = bus_a.out_last;
            if (bus_a.out_valid && bus_a.out_ready) begin
                got_q.push_back(bus_a.out_data);
                got_last.push_back(bus_a.out_last);
                hs_cyc.push_back(cyc);
            end
            if (bus_z.out_valid) begin
                z_q.push_back(bus_z.out_data);
                z_last.push_back(bus_z.out_last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snoop_write(input logic [31:0] addr, input logic [31:0] data);
        bus_a.dmem_we    = 1'b1;
        bus_a.dmem_waddr = addr;
        bus_a.dmem_wdata = data;
        tick();
        bus_a.dmem_we    = 1'b0;
        bus_a.dmem_waddr = '0;
        bus_a.dmem_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        got_q.delete();
        got_last.delete();
        hs_cyc.delete();
        z_q.delete();
        z_last.delete();
        rst = 1'b0;
        tick();
    endtask

    task automatic fill_random();
        for (int i = 0; i < NW; i++) mem_a[i] = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_halt"}, 32'(halt_a), 32'd0);
        check({tag, "_mem_re"}, 32'(bus_a.mem_re), 32'd0);
        check({tag, "_raddr"}, bus_a.mem_raddr, 32'd0);
        check({tag, "_valid"}, 32'(bus_a.out_valid), 32'd0);
        check({tag, "_data"}, bus_a.out_data, 32'd0);
        check({tag, "_last"}, 32'(bus_a.out_last), 32'd0);
        check({tag, "_done"}, 32'(done_a), 32'd0);
        check({tag, "_pass"}, 32'(pass_a), 32'd0);
    endtask

    // reference: header, the memory window in order, then the optional sum
    task automatic run_case(input logic [31:0] th, input bit rnd);
        logic [31:0] exp_q [$];
        logic [31:0] sum;
        int budget;
        got_q.delete();
        got_last.delete();
        hs_cyc.delete();
        exp_q.push_back(th);
        sum = th;
        for (int i = 0; i < NW; i++) begin
            exp_q.push_back(mem_a[i]);
            sum += mem_a[i];
        end
        if (CS) exp_q.push_back(sum);
        bus_a.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        snoop_write(TOHOST, th);
        check("halt_after_trig", 32'(halt_a), 32'd1);
        check("hdr_valid", 32'(bus_a.out_valid), 32'd1);
        check("hdr_data", bus_a.out_data, th);
        budget = 0;
        forever begin
            @(negedge clk);
            #1;
            if (got_q.size() >= exp_q.size() || budget > 400) break;
            @(posedge clk);
            #1;
            if (rnd) bus_a.out_ready = 1'($urandom_range(0, 1));
            budget++;
        end
        check("stream_len", 32'(got_q.size()), 32'(exp_q.size()));
        check("done_before_last_hs", 32'(done_a), 32'd0);
        tick();
        check("done_after_last_hs", 32'(done_a), 32'd1);
        check("valid_after_done", 32'(bus_a.out_valid), 32'd0);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("word%0d", i), got_q[i], exp_q[i]);
            check($sformatf("last%0d", i), 32'(got_last[i]), 32'(i == exp_q.size() - 1));
        end
        check("pass", 32'(pass_a), 32'(th == 32'h1));
        check("halt_held", 32'(halt_a), 32'd1);
        if (!rnd) begin
            for (int i = 1; i <= NW && i < hs_cyc.size(); i++)
                check($sformatf("spacing%0d", i), 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);
        end
    endtask

    initial begin
        bus_a.dmem_we    = 1'b0;
        bus_a.dmem_waddr = '0;
        bus_a.dmem_wdata = '0;
        bus_a.out_ready  = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        check_reset_outputs("rst");
        check("rst_halt_z", 32'(halt_z), 32'd0);
        check("rst_valid_z", 32'(bus_z.out_valid), 32'd0);
        rst = 1'b0;
        tick();

        // even value and wrong address do not trigger
        snoop_write(TOHOST, 32'h6);
        repeat (4) tick();
        check("no_trig_even_halt", 32'(halt_a), 32'd0);
        check("no_trig_even_valid", 32'(bus_a.out_valid), 32'd0);
        snoop_write(TOHOST + 32'd4, 32'h1);
        repeat (2) tick();
        check("no_trig_addr_halt", 32'(halt_a), 32'd0);

        mem_a[0] = 32'h11;
        mem_a[1] = 32'h22;
        mem_a[2] = 32'h33;
        mem_a[3] = 32'h44;
        run_case(32'h1, 1'b0);

        check("z_len", 32'(z_q.size()), CS ? 32'd2 : 32'd1);
        if (z_q.size() > 0) begin
            check("z_hdr", z_q[0], 32'h1);
            check("z_hdr_last", 32'(z_last[0]), 32'(!CS));
        end
        if (CS && z_q.size() > 1) begin
            check("z_csum", z_q[1], 32'h1);
            check("z_csum_last", 32'(z_last[1]), 32'd1);
        end
        check("z_done", 32'(done_z), 32'd1);
        check("z_pass", 32'(pass_z), 32'd1);

        // writes after the trigger are ignored
        snoop_write(TOHOST, 32'h3);
        repeat (3) tick();
        check("late_write_pass", 32'(pass_a), 32'd1);
        check("late_write_valid", 32'(bus_a.out_valid), 32'd0);
        check("late_write_done", 32'(done_a), 32'd1);
        check("late_write_halt", 32'(halt_a), 32'd1);

        do_reset();
        fill_random();
        run_case(32'h7, 1'b1);

        repeat (3) begin
            logic [31:0] th;
            do_reset();
            fill_random();
            th = $urandom;
            th[0] = 1'b1;
            run_case(th, 1'b1);
        end

        // reset while word 2 is stalled in SEND, then a fresh run
        do_reset();
        fill_random();
        bus_a.out_ready = 1'b1;
        snoop_write(TOHOST, 32'h1);
        for (int i = 0; i < 40 && !(bus_a.out_valid && got_q.size() >= 3); i++) begin
            if (got_q.size() >= 3) bus_a.out_ready = 1'b0;
            tick();
        end
        check("mid_valid", 32'(bus_a.out_valid), 32'd1);
        check("mid_word2", bus_a.out_data, mem_a[2]);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        rst = 1'b0;
        tick();
        bus_a.out_ready = 1'b1;
        got_q.delete();
        got_last.delete();
        hs_cyc.delete();
        run_case(32'h1, 1'b0);

        // trigger presented in the cycle reset is released
        rst = 1'b1;
        tick();
        rst = 1'b0;
        snoop_write(TOHOST, 32'h1);
        repeat (3) tick();
        check("rel_trig_halt", 32'(halt_a), 32'd0);
        check("rel_trig_valid", 32'(bus_a.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
